// File: rtl/csa_seq_pkg.sv
// Shared types and constants for the slice-serial carry skip adder sequencer.
package csa_seq_pkg;

    localparam int unsigned SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } csa_state_e;

    // Number of 4-bit slices needed to cover a given operand width.
    function automatic int unsigned nslice(input int unsigned width);
        return width / SLICE_W;
    endfunction

endpackage

// File: rtl/CSA.sv
// 4-bit carry skip adder: ripple chain with a block-propagate bypass of the carry-in.
module CSA (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    logic [3:0] p;
    logic [4:0] c;

    always_comb begin
        p    = a ^ b;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < 4; i++) begin
            c[i+1] = (a[i] & b[i]) | (p[i] & c[i]);
        end
        s    = p ^ c[3:0];
        // Whole block propagates: carry-in skips straight to the output.
        cout = (&p) ? cin : c[4];
    end

endmodule

// File: rtl/csa_seq_ctrl.sv
// Wide adder built by stepping one 4-bit CSA across WIDTH/4 slices, LSB slice first.
module csa_seq_ctrl
    import csa_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NSLICE = nslice(WIDTH);
    localparam int unsigned IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    generate
        if ((WIDTH % SLICE_W) != 0 || WIDTH < 8) begin : g_bad_width
            $error("csa_seq_ctrl: WIDTH must be a multiple of 4 and at least 8");
        end
    endgenerate

    csa_state_e       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic [IDX_W+1:0]   slice_lsb;
    logic [SLICE_W-1:0] csa_a, csa_b, csa_s;
    logic               csa_cout;

    // Operand slice select for the current step.
    always_comb begin
        slice_lsb = {idx_q, 2'b00};
        csa_a     = a_q[slice_lsb +: SLICE_W];
        csa_b     = b_q[slice_lsb +: SLICE_W];
    end

    CSA u_csa (
        .a    (csa_a),
        .b    (csa_b),
        .cin  (carry_q),
        .s    (csa_s),
        .cout (csa_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        idx_d   = idx_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                s_d[slice_lsb +: SLICE_W] = csa_s;
                carry_d                   = csa_cout;
                if (idx_q == IDX_W'(NSLICE - 1)) begin
                    // Overflow is latched with the final slice so it lands with s and cout.
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (s_d[WIDTH-1] != a_q[WIDTH-1]);
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign s         = s_q;
    assign cout      = carry_q;
    assign ovf       = ovf_q;

endmodule
